spi_seq_ctrl: RTL and testbench
===============================

Name: spi_seq_ctrl

Overview:
Transaction sequencer that drives the byte-level SPI controller. On a start command it streams N bytes from a synchronous TX buffer RAM into the SPI engine, one byte per handshake, and writes each received byte into an RX buffer RAM. It holds chip-select low across the whole burst, supports all-ones / all-zeros fill modes and aborts on a per-byte timeout. It sits between the register/instruction block and controlador_SPI.

Parameters:
ADDR_W, 9, buffer address width; a burst is at most 2^ADDR_W bytes
GAP_CYCLES, 2, idle cycles with CS held low between consecutive bytes (minimum 1)
TIMEOUT, 1024, max cycles in WAIT for spi_done_i before abort

Ports:
clk_i  in  1  system clock, single clock domain
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  start command; sampled only in IDLE
n_tx_end_i  in  ADDR_W  index of last byte; burst length = n_tx_end_i+1
all_1s_i  in  1  fill mode: send 0xFF for every byte
all_0s_i  in  1  fill mode: send 0x00 for every byte
tx_addr_o  out  ADDR_W  TX RAM read address
tx_data_i  in  8  TX RAM read data, valid 1 cycle after tx_addr_o
spi_start_o  out  1  1-cycle pulse that launches one byte in the SPI engine
spi_tx_data_o  out  8  byte for the SPI engine, stable from LOAD until the next LOAD
spi_done_i  in  1  SPI engine byte-complete pulse
spi_rx_data_i  in  8  received byte, valid when spi_done_i=1
rx_we_o  out  1  RX RAM write enable, 1-cycle pulse
rx_addr_o  out  ADDR_W  RX RAM write address
rx_data_o  out  8  RX RAM write data
cs_o  out  1  chip select, active low
busy_o  out  1  high in every state except IDLE
done_o  out  1  1-cycle pulse when a burst completes normally
err_o  out  1  1-cycle pulse on timeout abort
n_rx_o  out  ADDR_W+1  count of bytes stored in the current or last burst

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - State goes to IDLE. cs_o=1.
  - All other outputs are 0, and all counters are cleared.
  - Reset mid-burst aborts immediately. No done_o or err_o pulse is generated.
- States: IDLE, FETCH, LOAD, SEND, WAIT, STORE, GAP, DONE, ABORT.
- IDLE:
  - When start_i=1, latch n_tx_end_i, all_1s_i and all_0s_i; clear idx and n_rx_o; go to FETCH.
  - start_i is ignored in every other state.
- FETCH: tx_addr_o=idx; cs_o=0 (registered, so low from the first FETCH cycle); go to LOAD.
- LOAD:
  - spi_tx_data_o = 0xFF if all_1s is latched, else 0x00 if all_0s is latched, else tx_data_i. all_1s has priority over all_0s.
  - Go to SEND.
- SEND: spi_start_o=1 for exactly 1 cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On spi_done_i=1, capture spi_rx_data_i and go to STORE.
  - If the timeout counter reaches TIMEOUT-1 with no done, go to ABORT.
  - spi_done_i in any other state is ignored.
- STORE: rx_we_o=1, rx_addr_o=idx, rx_data_o=captured byte; n_rx_o increments.
  - If idx==latched n_tx_end, go to DONE.
  - Otherwise idx increments and the FSM goes to GAP.
- GAP: hold cs_o=0 for GAP_CYCLES cycles, then go to FETCH.
- DONE: cs_o=1, done_o=1 for 1 cycle, go to IDLE.
- ABORT: cs_o=1, err_o=1 for 1 cycle, go to IDLE. n_rx_o keeps the number of bytes stored before the abort.
- Widths and wrap-around:
  - idx is ADDR_W bits and never wraps, because the end check occurs before the increment.
  - n_rx_o is ADDR_W+1 bits so it can represent 2^ADDR_W without overflow.
  - n_tx_end=2^ADDR_W-1 transfers the full buffer.
- Per-byte latency, excluding SPI engine time: start_i to spi_start_o is 3 cycles (FETCH, LOAD, SEND).
- Inter-byte spacing after spi_done_i: STORE + GAP_CYCLES + FETCH + LOAD + SEND.
- Input changes: changes to n_tx_end_i, all_1s_i or all_0s_i during a burst have no effect.

Decomposition:
- Package spi_seq_pkg:
  - state enum typedef.
  - FILL_ONES=8'hFF and FILL_ZEROS=8'h00 constants.
  - Shared ADDR_W default.
- Sub-module spi_seq_timer: loadable down-counter with a clear input and an expired output.
  - Used for both the GAP count and the WAIT timeout, with the load value muxed by state.

Test Plan:
- Normal burst: n_tx_end_i=3, TX RAM = {A5,3C,0F,F0}, SPI model echoes inverted bytes after 20 cycles.
  - Expect RX RAM = {5A,C3,F0,0F}, 4 rx_we_o pulses at addresses 0..3, n_rx_o=4, 1 done_o pulse.
  - Expect cs_o low continuously from the first FETCH to DONE.
- Fill modes: all_1s_i=1 and all_0s_i=1 both asserted, n_tx_end_i=1 → spi_tx_data_o=FF for both bytes. Repeat with only all_0s_i=1 → 00 for both bytes.
- Timeout: the SPI model never returns done on byte 2 of a 4-byte burst.
  - Expect err_o after TIMEOUT cycles in WAIT, cs_o=1, n_rx_o=1, no done_o.
- Reset mid-burst: assert rst_i during WAIT of byte 1.
  - Expect cs_o=1, busy_o=0, n_rx_o=0 at the next edge and no pulses.
  - A subsequent start_i runs a clean burst.
- Boundary: n_tx_end_i=0 gives exactly 1 byte. With ADDR_W=4 and n_tx_end_i=15, expect 16 writes, n_rx_o=16, no address wrap.
- Command robustness:
  - start_i held high through a burst → exactly one burst, then a new one starts from IDLE.
  - spi_done_i pulsed during GAP → ignored; the byte count is unchanged.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and constants for the SPI transaction sequencer
package spi_seq_pkg;

  localparam int SEQ_ADDR_W = 9;

  localparam logic [7:0] FILL_ONES  = 8'hFF;
  localparam logic [7:0] FILL_ZEROS = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_STORE,
    S_GAP,
    S_DONE,
    S_ABORT
  } seq_state_t;

endpackage

// File: rtl/spi_seq_timer.sv
// rtl/spi_seq_timer.sv - loadable down-counter shared by the GAP count and the WAIT timeout
module spi_seq_timer #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Counts down to zero and parks there; expired marks the last cycle of the loaded window.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/spi_seq_ctrl.sv
// rtl/spi_seq_ctrl.sv - burst sequencer streaming TX buffer bytes through the SPI engine into the RX buffer
module spi_seq_ctrl
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W     = SEQ_ADDR_W,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] n_tx_end_i,
  input  logic              all_1s_i,
  input  logic              all_0s_i,
  output logic [ADDR_W-1:0] tx_addr_o,
  input  logic [7:0]        tx_data_i,
  output logic              spi_start_o,
  output logic [7:0]        spi_tx_data_o,
  input  logic              spi_done_i,
  input  logic [7:0]        spi_rx_data_i,
  output logic              rx_we_o,
  output logic [ADDR_W-1:0] rx_addr_o,
  output logic [7:0]        rx_data_o,
  output logic              cs_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   n_rx_o
);

  localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  seq_state_t        state, state_nx;
  logic [ADDR_W-1:0] idx, n_end;
  logic              ones_q, zeros_q, cs_q, seq_last;
  logic [7:0]        tx_byte, rx_byte;
  logic [ADDR_W:0]   n_rx;
  logic              tmr_clr, tmr_load, tmr_expired;
  logic [TW-1:0]     tmr_val;

  assign seq_last = (idx == n_end);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start_i) state_nx = S_FETCH;
      S_FETCH: state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SEND;
      S_SEND:  state_nx = S_WAIT;
      S_WAIT: begin
        if (spi_done_i)       state_nx = S_STORE;
        else if (tmr_expired) state_nx = S_ABORT;
      end
      S_STORE: state_nx = seq_last ? S_DONE : S_GAP;
      S_GAP:   if (tmr_expired) state_nx = S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      S_ABORT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    spi_start_o = 1'b0;
    rx_we_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    busy_o      = 1'b1;
    unique case (state)
      S_IDLE:  busy_o      = 1'b0;
      S_SEND:  spi_start_o = 1'b1;
      S_STORE: rx_we_o     = 1'b1;
      S_DONE:  done_o      = 1'b1;
      S_ABORT: err_o       = 1'b1;
      default: ;
    endcase
  end

  // One timer serves both windows: the timeout is armed in SEND, the gap in STORE.
  assign tmr_clr  = (state == S_IDLE);
  assign tmr_load = (state == S_SEND) || (state == S_STORE);
  assign tmr_val  = (state == S_SEND) ? TO_LOAD : GAP_LOAD;

  spi_seq_timer #(.W(TW)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx     <= '0;
      n_end   <= '0;
      ones_q  <= 1'b0;
      zeros_q <= 1'b0;
      tx_byte <= '0;
      rx_byte <= '0;
      n_rx    <= '0;
      cs_q    <= 1'b1;
    end else begin
      // Driven from next state so CS falls in the first FETCH cycle and rises in DONE/ABORT.
      cs_q <= !(state_nx inside {S_FETCH, S_LOAD, S_SEND, S_WAIT, S_STORE, S_GAP});
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            n_end   <= n_tx_end_i;
            ones_q  <= all_1s_i;
            zeros_q <= all_0s_i;
            idx     <= '0;
            n_rx    <= '0;
          end
        end
        S_LOAD:  tx_byte <= ones_q ? FILL_ONES : (zeros_q ? FILL_ZEROS : tx_data_i);
        S_WAIT:  if (spi_done_i) rx_byte <= spi_rx_data_i;
        S_STORE: begin
          n_rx <= n_rx + 1'b1;
          if (!seq_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx_addr_o     = idx;
  assign rx_addr_o     = idx;
  assign rx_data_o     = rx_byte;
  assign spi_tx_data_o = tx_byte;
  assign cs_o          = cs_q;
  assign n_rx_o        = n_rx;

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// tb/tb_spi_seq_ctrl.sv - scoreboard bench for spi_seq_ctrl with TX/RX RAM and echoing SPI engine models
module tb_spi_seq_ctrl;

  localparam int AW  = 4;
  localparam int GAP = 2;
  localparam int TO  = 1024;
  localparam int LAT = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] n_tx_end;
  logic          all_1s, all_0s;
  logic [AW-1:0] tx_addr;
  logic [7:0]    tx_data;
  logic          spi_start;
  logic [7:0]    spi_tx_data;
  logic          spi_done, model_done, gap_done;
  logic [7:0]    spi_rx_data, model_rx;
  logic          rx_we;
  logic [AW-1:0] rx_addr;
  logic [7:0]    rx_data;
  logic          cs, busy, done, err;
  logic [AW:0]   n_rx;

  logic [7:0]    tx_mem [16];
  logic [7:0]    rx_mem [16];
  logic [AW+7:0] exp_rx [$];
  logic [7:0]    exp_tx [$];
  logic [AW+7:0] mon_e;
  logic [7:0]    mon_b;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0, cs_viol = 0;
  int start_cyc = 0, err_cyc = 0, starts_seen = 0, drop_start = 0;
  bit mon_en = 1'b0;

  initial forever #5 clk = ~clk;

  assign spi_done    = model_done | gap_done;
  assign spi_rx_data = gap_done ? 8'h77 : model_rx;

  spi_seq_ctrl #(.ADDR_W(AW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .n_tx_end_i(n_tx_end),
    .all_1s_i(all_1s), .all_0s_i(all_0s), .tx_addr_o(tx_addr), .tx_data_i(tx_data),
    .spi_start_o(spi_start), .spi_tx_data_o(spi_tx_data), .spi_done_i(spi_done),
    .spi_rx_data_i(spi_rx_data), .rx_we_o(rx_we), .rx_addr_o(rx_addr), .rx_data_o(rx_data),
    .cs_o(cs), .busy_o(busy), .done_o(done), .err_o(err), .n_rx_o(n_rx)
  );

  always @(posedge clk) tx_data <= tx_mem[tx_addr];

  // SPI engine model: echoes the inverted byte LAT cycles after each launch.
  initial begin
    model_done = 1'b0;
    model_rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin : launch_seen
        logic [7:0] b;
        bit alive;
        b = spi_tx_data;
        starts_seen++;
        alive = (starts_seen != drop_start);
        for (int k = 0; k < LAT && alive; k++) begin
          @(posedge clk); #1;
          if (busy !== 1'b1) alive = 1'b0;
        end
        if (alive) begin
          model_rx = ~b; model_done = 1'b1;
          @(posedge clk); #1;
          model_done = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: pops expected TX launches and RX writes as the DUT produces them.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (rx_we === 1'b1) begin
        we_cnt++;
        rx_mem[rx_addr] = rx_data;
        n_cmp++;
        if (exp_rx.size() == 0) begin
          n_bad++;
          $display("FAIL rx_write: got unexpected addr=%0d data=%02h, required no write", rx_addr, rx_data);
        end else begin
          mon_e = exp_rx.pop_front();
          if ({rx_addr, rx_data} !== mon_e) begin
            n_bad++;
            $display("FAIL rx_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     rx_addr, rx_data, mon_e[AW+7:8], mon_e[7:0]);
          end
        end
      end
      if (spi_start === 1'b1) begin
        start_cyc = cyc;
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_bad++;
          $display("FAIL spi_tx: got unexpected launch data=%02h, required none", spi_tx_data);
        end else begin
          mon_b = exp_tx.pop_front();
          if (spi_tx_data !== mon_b) begin
            n_bad++;
            $display("FAIL spi_tx: got %02h, required %02h", spi_tx_data, mon_b);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (cs !== !(busy === 1'b1 && done !== 1'b1 && err !== 1'b1)) cs_viol++;
    end
  end

  task automatic push_exp(input int n_end, input bit ones, input bit zeros);
    logic [7:0] b;
    logic [AW-1:0] a;
    for (int i = 0; i <= n_end; i++) begin
      b = ones ? 8'hFF : (zeros ? 8'h00 : tx_mem[i]);
      a = AW'(i);
      exp_tx.push_back(b);
      exp_rx.push_back({a, ~b});
    end
  endtask

  task automatic launch(input int n_end, input bit ones, input bit zeros);
    @(posedge clk); #1;
    n_tx_end = AW'(n_end); all_1s = ones; all_0s = zeros; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL wait_end: got no done/err in %0d cycles, required completion", budget); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (cs !== 1'b1) begin n_bad++; $display("FAIL reset_cs: got %b, required 1", cs); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if ({spi_start, rx_we, done, err} !== 4'b0) begin n_bad++; $display("FAIL reset_pulses: got %b, required 0000", {spi_start, rx_we, done, err}); end
    n_cmp++; if (n_rx !== '0) begin n_bad++; $display("FAIL reset_n_rx: got %0d, required 0", n_rx); end
    n_cmp++; if ({tx_addr, rx_addr, spi_tx_data, rx_data} !== '0) begin n_bad++; $display("FAIL reset_data: got %h, required 0", {tx_addr, rx_addr, spi_tx_data, rx_data}); end
  endtask

  task automatic test_normal();
    logic [7:0] want [4];
    int d0, w0, c0;
    want = '{8'h5A, 8'hC3, 8'hF0, 8'h0F};
    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'h0F; tx_mem[3] = 8'hF0;
    d0 = done_cnt; w0 = we_cnt; c0 = cs_viol;
    push_exp(3, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_tx_end = 4'd3; all_1s = 1'b0; all_0s = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n_tx_end = 4'd0; all_1s = 1'b1; all_0s = 1'b1;
    n_cmp++; if ({cs, busy, spi_start, tx_addr} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin n_bad++; $display("FAIL fetch_cycle: got cs=%b busy=%b start=%b addr=%0d, required 0 1 0 0", cs, busy, spi_start, tx_addr); end
    @(posedge clk); #1;
    n_cmp++; if (spi_start !== 1'b0) begin n_bad++; $display("FAIL latency_load: got %b, required 0", spi_start); end
    @(posedge clk); #1;
    n_cmp++; if (spi_start !== 1'b1) begin n_bad++; $display("FAIL latency_send: got %b, required 1", spi_start); end
    wait_end(400);
    all_1s = 1'b0; all_0s = 1'b0;
    n_cmp++; if (n_rx !== 5'd4) begin n_bad++; $display("FAIL normal_n_rx: got %0d, required 4", n_rx); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL normal_done: got %0d, required 1", done_cnt - d0); end
    n_cmp++; if (we_cnt - w0 !== 4) begin n_bad++; $display("FAIL normal_writes: got %0d, required 4", we_cnt - w0); end
    n_cmp++; if (cs_viol !== c0) begin n_bad++; $display("FAIL normal_cs: got %0d cs violations, required 0", cs_viol - c0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx_mem[i] !== want[i]) begin n_bad++; $display("FAIL normal_rx_mem[%0d]: got %02h, required %02h", i, rx_mem[i], want[i]); end
    end
  endtask

  task automatic test_fill();
    push_exp(1, 1'b1, 1'b1);
    launch(1, 1'b1, 1'b1);
    wait_end(300);
    push_exp(1, 1'b0, 1'b1);
    launch(1, 1'b0, 1'b1);
    wait_end(300);
    all_0s = 1'b0;
    n_cmp++; if (n_rx !== 5'd2) begin n_bad++; $display("FAIL fill_n_rx: got %0d, required 2", n_rx); end
    n_cmp++; if (rx_mem[0] !== 8'hFF || rx_mem[1] !== 8'hFF) begin n_bad++; $display("FAIL fill_zeros_rx: got %02h %02h, required ff ff", rx_mem[0], rx_mem[1]); end
    n_cmp++; if (exp_tx.size() + exp_rx.size() !== 0) begin n_bad++; $display("FAIL fill_queue: got %0d left, required 0", exp_tx.size() + exp_rx.size()); end
  endtask

  task automatic test_timeout();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    drop_start = starts_seen + 2;
    push_exp(3, 1'b0, 1'b0);
    launch(3, 1'b0, 1'b0);
    wait_end(TO + 400);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_err: got %0d, required 1", err_cnt - e0); end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL timeout_done: got %0d, required 0", done_cnt - d0); end
    n_cmp++; if (n_rx !== 5'd1) begin n_bad++; $display("FAIL timeout_n_rx: got %0d, required 1", n_rx); end
    n_cmp++; if ({cs, busy} !== 2'b10) begin n_bad++; $display("FAIL timeout_idle: got cs=%b busy=%b, required 1 0", cs, busy); end
    n_cmp++; if (err_cyc - start_cyc !== TO + 1) begin n_bad++; $display("FAIL timeout_len: got %0d, required %0d", err_cyc - start_cyc, TO + 1); end
    n_cmp++; if (exp_tx.size() !== 2 || exp_rx.size() !== 3) begin n_bad++; $display("FAIL timeout_left: got tx=%0d rx=%0d, required 2 3", exp_tx.size(), exp_rx.size()); end
    exp_tx.delete(); exp_rx.delete();
    drop_start = 0;
  endtask

  task automatic test_reset_mid();
    int d0, e0, w0, seen;
    seen = 0;
    push_exp(3, 1'b0, 1'b0);
    launch(3, 1'b0, 1'b0);
    for (int k = 0; k < 300 && seen < 1; k++) begin
      @(negedge clk);
      if (spi_start === 1'b1 && n_rx == 5'd1) seen++;
    end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    @(posedge clk); #1 rst = 1'b0;
    n_cmp++; if ({cs, busy, n_rx} !== {1'b1, 1'b0, 5'd0}) begin n_bad++; $display("FAIL reset_mid: got cs=%b busy=%b n_rx=%0d, required 1 0 0", cs, busy, n_rx); end
    repeat (LAT + 10) @(negedge clk);
    n_cmp++; if ({done_cnt - d0, err_cnt - e0, we_cnt - w0} !== {32'd0, 32'd0, 32'd0}) begin n_bad++; $display("FAIL reset_mid_pulses: got done=%0d err=%0d we=%0d, required 0", done_cnt - d0, err_cnt - e0, we_cnt - w0); end
    exp_tx.delete(); exp_rx.delete();
    for (int i = 0; i < 4; i++) tx_mem[i] = 8'(8'h11 * (i + 1));
    push_exp(3, 1'b0, 1'b0);
    launch(3, 1'b0, 1'b0);
    wait_end(400);
    n_cmp++; if (n_rx !== 5'd4 || done_cnt - d0 !== 1) begin n_bad++; $display("FAIL reset_recover: got n_rx=%0d done=%0d, required 4 1", n_rx, done_cnt - d0); end
  endtask

  task automatic test_boundary();
    int w0;
    w0 = we_cnt;
    tx_mem[0] = 8'($urandom);
    push_exp(0, 1'b0, 1'b0);
    launch(0, 1'b0, 1'b0);
    wait_end(200);
    n_cmp++; if (n_rx !== 5'd1 || we_cnt - w0 !== 1) begin n_bad++; $display("FAIL single_byte: got n_rx=%0d writes=%0d, required 1 1", n_rx, we_cnt - w0); end
    for (int i = 0; i < 16; i++) tx_mem[i] = 8'($urandom);
    w0 = we_cnt;
    push_exp(15, 1'b0, 1'b0);
    launch(15, 1'b0, 1'b0);
    wait_end(16 * 60);
    n_cmp++; if (n_rx !== 5'd16 || we_cnt - w0 !== 16) begin n_bad++; $display("FAIL full_buffer: got n_rx=%0d writes=%0d, required 16 16", n_rx, we_cnt - w0); end
    n_cmp++; if (rx_mem[0] !== ~tx_mem[0] || rx_mem[15] !== ~tx_mem[15]) begin n_bad++; $display("FAIL full_ends: got %02h %02h, required %02h %02h", rx_mem[0], rx_mem[15], ~tx_mem[0], ~tx_mem[15]); end
  endtask

  task automatic test_back_to_back();
    int d0, w0;
    d0 = done_cnt; w0 = we_cnt;
    push_exp(1, 1'b0, 1'b0);
    push_exp(1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_tx_end = 4'd1; start = 1'b1;
    wait_end(300);
    @(posedge clk); #1 start = 1'b0;
    wait_end(300);
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 2 || we_cnt - w0 !== 4) begin n_bad++; $display("FAIL held_start: got done=%0d writes=%0d, required 2 4", done_cnt - d0, we_cnt - w0); end
    n_cmp++; if (busy !== 1'b0 || exp_tx.size() + exp_rx.size() !== 0) begin n_bad++; $display("FAIL held_start_end: got busy=%b left=%0d, required 0 0", busy, exp_tx.size() + exp_rx.size()); end
  endtask

  task automatic test_gap_done();
    int w0;
    bit seen = 1'b0;
    w0 = we_cnt;
    push_exp(2, 1'b0, 1'b0);
    launch(2, 1'b0, 1'b0);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (rx_we === 1'b1) seen = 1'b1;
    end
    @(posedge clk); #1 gap_done = 1'b1;
    @(posedge clk); #1 gap_done = 1'b0;
    wait_end(300);
    n_cmp++; if (n_rx !== 5'd3 || we_cnt - w0 !== 3) begin n_bad++; $display("FAIL gap_done: got n_rx=%0d writes=%0d, required 3 3", n_rx, we_cnt - w0); end
    n_cmp++; if (exp_tx.size() + exp_rx.size() !== 0) begin n_bad++; $display("FAIL gap_queue: got %0d left, required 0", exp_tx.size() + exp_rx.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_tx_end = '0; all_1s = 1'b0; all_0s = 1'b0; gap_done = 1'b0;
    for (int i = 0; i < 16; i++) begin tx_mem[i] = 8'h00; rx_mem[i] = 8'h00; end
    test_reset();
    test_normal();
    test_fill();
    test_timeout();
    test_reset_mid();
    test_boundary();
    test_back_to_back();
    test_gap_done();
    n_cmp++; if (cs_viol !== 0) begin n_bad++; $display("FAIL cs_track: got %0d violations, required 0", cs_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
